alu_pipe: RTL and testbench

- Parametrised, two-stage pipelined successor to the single-cycle 16-bit ALU.
- Executes the full 4-bit opcode set: ADD, SUB, XOR, SLL, SRA, ROR, PADDSB, LW/SW address generation, LLB and LHB.
- Uses valid/ready handshakes on input and output, and holds an architectural {N,V,Z} flag register.
- Sits between decode and writeback in the pipelined CPU.

---
 rtl/alu_pipe.sv | 197 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU with saturating arithmetic,
// shifts, lane-wise PADDSB, address generation and byte loads.
module alu_pipe #(
  parameter int WIDTH  = 16,
  parameter int LANE_W = 4,
  parameter int IMM_W  = 8,
  parameter int SH_W   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Opcode,
  input  logic [WIDTH-1:0] Reg1,
  input  logic [WIDTH-1:0] Reg2,
  input  logic [IMM_W-1:0] Imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Output,
  output logic [2:0]       Flag,
  output logic             flag_we
);

  localparam int MSB = WIDTH - 1;
  localparam int NL  = WIDTH / LANE_W;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;
  localparam logic [3:0] OP_PAD = 4'h7;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LLB = 4'ha;
  localparam logic [3:0] OP_LHB = 4'hb;

  if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0 ||
      WIDTH % LANE_W != 0 || IMM_W < 8 ||
      IMM_W >= WIDTH || SH_W > 31) begin : g_bad_cfg
    $error("alu_pipe: unsupported parameter set");
  end

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [IMM_W-1:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             wnv;
    logic             wz;
    logic             n;
    logic             v;
    logic             z;
  } ex_wb_t;

  id_ex_t s1;
  ex_wb_t s2, ex;
  logic   s1_valid, s2_valid, rdy_q;
  logic   s2_free, in_fire, out_fire;
  logic   fn, fv, fz;

  assign s2_free   = !s2_valid || out_ready;
  assign in_ready  = rdy_q && (!s1_valid || s2_free);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = s2_valid && out_ready;
  assign out_valid = s2_valid;
  assign Output    = s2.res;
  assign Flag      = {fn, fv, fz};
  assign flag_we   = s2_valid && (s2.wnv || s2.wz);

  logic [WIDTH-1:0]   add_sum, sub_dif, sat;
  logic               add_ovf, sub_ovf;
  logic [SH_W-1:0]    sh;
  logic [WIDTH-1:0]   sll_r, sra_r, ror_r;
  logic [2*WIDTH-1:0] ror_x;
  logic [WIDTH-1:0]   agen, off, llb_r, lhb_r, imm_x;
  logic [WIDTH-1:0]   padd;

  assign add_sum = s1.a + s1.b;
  assign sub_dif = s1.a - s1.b;
  assign add_ovf = (s1.a[MSB] == s1.b[MSB]) &&
                   (add_sum[MSB] != s1.a[MSB]);
  assign sub_ovf = (s1.a[MSB] != s1.b[MSB]) &&
                   (sub_dif[MSB] != s1.a[MSB]);
  // overflow direction always follows the sign of Reg1
  assign sat = {s1.a[MSB], {(WIDTH-1){~s1.a[MSB]}}};

  assign sh    = s1.imm[SH_W-1:0];
  assign sll_r = s1.a << sh;
  assign sra_r = $signed(s1.a) >>> sh;
  assign ror_x = {s1.a, s1.a} >> sh;
  assign ror_r = ror_x[WIDTH-1:0];

  assign off   = {{(WIDTH-5){s1.imm[3]}}, s1.imm[3:0], 1'b0};
  assign agen  = {s1.a[MSB:1], 1'b0} + off;
  assign imm_x = {{(WIDTH-IMM_W){1'b0}}, s1.imm};
  assign llb_r = {s1.a[MSB:8], 8'h00} | imm_x;
  assign lhb_r = {s1.imm[7:0], s1.a[MSB-8:0]};

  for (genvar l = 0; l < NL; l++) begin : g_lane
    logic [LANE_W-1:0] la, lb, ls;
    logic              ovf;
    assign la  = s1.a[l*LANE_W +: LANE_W];
    assign lb  = s1.b[l*LANE_W +: LANE_W];
    assign ls  = la + lb;
    assign ovf = (la[LANE_W-1] == lb[LANE_W-1]) &&
                 (ls[LANE_W-1] != la[LANE_W-1]);
    assign padd[l*LANE_W +: LANE_W] = ovf ?
      {la[LANE_W-1], {(LANE_W-1){~la[LANE_W-1]}}} : ls;
  end

  always_comb begin
    ex = '0;
    unique case (1'b1)
      s1.op == OP_ADD: begin
        ex.res = add_ovf ? sat : add_sum;
        ex.v   = add_ovf;
        ex.wnv = 1'b1;
        ex.wz  = 1'b1;
      end
      s1.op == OP_SUB: begin
        ex.res = sub_ovf ? sat : sub_dif;
        ex.v   = sub_ovf;
        ex.wnv = 1'b1;
        ex.wz  = 1'b1;
      end
      s1.op == OP_XOR: begin
        ex.res = s1.a ^ s1.b;
        ex.wz  = 1'b1;
      end
      s1.op == OP_SLL: begin
        ex.res = sll_r;
        ex.wz  = 1'b1;
      end
      s1.op == OP_SRA: begin
        ex.res = sra_r;
        ex.wz  = 1'b1;
      end
      s1.op == OP_ROR: begin
        ex.res = ror_r;
        ex.wz  = 1'b1;
      end
      s1.op == OP_PAD: ex.res = padd;
      s1.op == OP_LW,
      s1.op == OP_SW:  ex.res = agen;
      s1.op == OP_LLB: ex.res = llb_r;
      s1.op == OP_LHB: ex.res = lhb_r;
      default:         ex.res = '0;
    endcase
    ex.n = ex.res[MSB];
    ex.z = (ex.res == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q    <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1       <= '{op: Opcode, a: Reg1,
                      b: Reg2, imm: Imm};
      end else if (s2_free) begin
        s1_valid <= 1'b0;
      end
      if (s2_free) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2 <= ex;
      end
    end
  end

  // architectural flags commit only on the output handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fn <= 1'b0;
      fv <= 1'b0;
      fz <= 1'b0;
    end else if (out_fire) begin
      if (s2.wnv) begin
        fn <= s2.n;
        fv <= s2.v;
      end
      if (s2.wz) fz <= s2.z;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe
// at WIDTH=16 and WIDTH=32 against an arithmetic model.
module tb_alu_pipe;

  typedef struct packed {
    logic [31:0] r;
    logic        wnv;
    logic        wz;
    logic        v;
  } exp_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  imm;
    logic [31:0] r;
    logic [2:0]  f;
    logic        we;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv, ir, ov, ordy, fwe;
  logic [3:0]  op;
  logic [15:0] ra, rb, dout;
  logic [7:0]  imm;
  logic [2:0]  flag;

  logic        iv2, ir2, ov2, ordy2, fwe2;
  logic [3:0]  op2;
  logic [31:0] ra2, rb2, dout2;
  logic [7:0]  imm2;
  logic [2:0]  flag2;

  int          errors = 0;
  int          checks = 0;
  logic [2:0]  mf16 = 3'b000;
  exp_t        q[$];

  alu_pipe u16 (
    .clk(clk), .rst(rst),
    .in_valid(iv), .in_ready(ir),
    .Opcode(op), .Reg1(ra), .Reg2(rb), .Imm(imm),
    .out_valid(ov), .out_ready(ordy),
    .Output(dout), .Flag(flag), .flag_we(fwe)
  );

  alu_pipe #(.WIDTH(32), .LANE_W(8)) u32 (
    .clk(clk), .rst(rst),
    .in_valid(iv2), .in_ready(ir2),
    .Opcode(op2), .Reg1(ra2), .Reg2(rb2), .Imm(imm2),
    .out_valid(ov2), .out_ready(ordy2),
    .Output(dout2), .Flag(flag2), .flag_we(fwe2)
  );

  function automatic longint sx(longint x, int w);
    longint v;
    v = x & ((longint'(1) << w) - 1);
    if (((v >> (w - 1)) & 1) != 0) v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic exp_t ref_op(int w, int lw, logic [3:0] o,
                                  logic [31:0] a, logic [31:0] b,
                                  logic [7:0] im);
    exp_t   e;
    longint m, mx, mn, s, lm, lmx, lmn, ua;
    int     sh;
    e   = '0;
    m   = (longint'(1) << w) - 1;
    mx  = (longint'(1) << (w - 1)) - 1;
    mn  = -mx - 1;
    sh  = int'(im) % w;
    ua  = longint'(a);
    case (o)
      4'h0, 4'h1: begin
        s = (o == 4'h0) ? sx(ua, w) + sx(longint'(b), w)
                        : sx(ua, w) - sx(longint'(b), w);
        e.v = (s > mx) || (s < mn);
        if (s > mx) s = mx;
        if (s < mn) s = mn;
        e.r = 32'(s & m);
        e.wnv = 1'b1;
        e.wz = 1'b1;
      end
      4'h2: begin e.r = a ^ b; e.wz = 1'b1; end
      4'h4: begin e.r = 32'((ua << sh) & m); e.wz = 1'b1; end
      4'h5: begin e.r = 32'((sx(ua, w) >>> sh) & m); e.wz = 1'b1; end
      4'h6: begin
        e.r = 32'(((ua >> sh) | (ua << (w - sh))) & m);
        e.wz = 1'b1;
      end
      4'h7: begin
        lm  = (longint'(1) << lw) - 1;
        lmx = (longint'(1) << (lw - 1)) - 1;
        lmn = -lmx - 1;
        for (int l = 0; l < w / lw; l++) begin
          s = sx(ua >> (l * lw), lw) + sx(longint'(b) >> (l * lw), lw);
          if (s > lmx) s = lmx;
          if (s < lmn) s = lmn;
          e.r = e.r | 32'((s & lm) << (l * lw));
        end
      end
      4'h8, 4'h9:
        e.r = 32'(((ua & ~longint'(1)) + 2 * sx(longint'(im), 4)) & m);
      4'ha: e.r = 32'((ua & ~longint'(255)) | longint'(im));
      4'hb: e.r = 32'((ua & ((longint'(1) << (w - 8)) - 1)) |
                      (longint'(im) << (w - 8)));
      default: e.r = '0;
    endcase
    return e;
  endfunction

  function automatic logic [2:0] upd(logic [2:0] f, exp_t e, int w);
    logic [2:0] n;
    n = f;
    if (e.wnv) begin
      n[2] = e.r[w-1];
      n[1] = e.v;
    end
    if (e.wz) n[0] = (e.r == 32'h0);
    return n;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (ov !== 1'b0 || dout !== 16'h0 || flag !== 3'b000 || fwe !== 1'b0) begin
      errors++;
      $display("FAIL reset_state ov=%b out=%h flag=%b we=%b", ov, dout, flag, fwe);
    end
    checks++;
    if (ov2 !== 1'b0 || dout2 !== 32'h0 || flag2 !== 3'b000) begin
      errors++;
      $display("FAIL reset_state32 ov=%b out=%h flag=%b", ov2, dout2, flag2);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ir !== 1'b1 || ir2 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b%b want=11", ir, ir2);
    end
  endtask

  task automatic test_single();
    vec_t t[17];
    t[0]  = '{4'h8, 32'h0001, 32'h0000, 8'h05, 32'h000a, 3'b000, 1'b0};
    t[1]  = '{4'h9, 32'h0010, 32'h0000, 8'hfe, 32'h000c, 3'b000, 1'b0};
    t[2]  = '{4'ha, 32'h0a01, 32'h0000, 8'hf0, 32'h0af0, 3'b000, 1'b0};
    t[3]  = '{4'hb, 32'habcd, 32'h0000, 8'h01, 32'h01cd, 3'b000, 1'b0};
    t[4]  = '{4'h0, 32'h7ffe, 32'h7ffe, 8'h00, 32'h7fff, 3'b010, 1'b1};
    t[5]  = '{4'h1, 32'h0005, 32'h0007, 8'h00, 32'hfffe, 3'b100, 1'b1};
    t[6]  = '{4'h4, 32'hab00, 32'h0000, 8'h08, 32'h0000, 3'b101, 1'b1};
    t[7]  = '{4'ha, 32'h0a01, 32'h0000, 8'hf0, 32'h0af0, 3'b101, 1'b0};
    t[8]  = '{4'h7, 32'h0123, 32'h45f6, 8'h00, 32'h4617, 3'b101, 1'b0};
    t[9]  = '{4'h7, 32'h7777, 32'h1111, 8'h00, 32'h7777, 3'b101, 1'b0};
    t[10] = '{4'h2, 32'hffff, 32'h0f0f, 8'h00, 32'hf0f0, 3'b100, 1'b1};
    t[11] = '{4'h3, 32'h1234, 32'h5678, 8'h12, 32'h0000, 3'b100, 1'b0};
    t[12] = '{4'hc, 32'h1234, 32'h5678, 8'h12, 32'h0000, 3'b100, 1'b0};
    t[13] = '{4'h5, 32'h8000, 32'h0000, 8'h04, 32'hf800, 3'b100, 1'b1};
    t[14] = '{4'h6, 32'h1234, 32'h0000, 8'h10, 32'h1234, 3'b100, 1'b1};
    t[15] = '{4'h6, 32'h0001, 32'h0000, 8'h04, 32'h1000, 3'b100, 1'b1};
    t[16] = '{4'h1, 32'h8000, 32'h0001, 8'h00, 32'h8000, 3'b110, 1'b1};
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      iv = 1'b1; op = t[i].op; ra = t[i].a[15:0];
      rb = t[i].b[15:0]; imm = t[i].imm; ordy = 1'b1;
      #1;
      checks++;
      if (ir !== 1'b1) begin
        errors++;
        $display("FAIL single_ready[%0d] got=%b want=1", i, ir);
      end
      @(posedge clk);
      #1 iv = 1'b0;
      @(negedge clk);
      checks++;
      if (ov !== 1'b0) begin
        errors++;
        $display("FAIL single_early[%0d] ov=%b want=0", i, ov);
      end
      @(negedge clk);
      checks++;
      if (ov !== 1'b1 || dout !== t[i].r[15:0]) begin
        errors++;
        $display("FAIL single_out[%0d] ov=%b got=%h want=%h", i, ov, dout, t[i].r[15:0]);
      end
      checks++;
      if (fwe !== t[i].we) begin
        errors++;
        $display("FAIL single_we[%0d] got=%b want=%b", i, fwe, t[i].we);
      end
      @(posedge clk);
      #1;
      checks++;
      if (flag !== t[i].f) begin
        errors++;
        $display("FAIL single_flag[%0d] got=%b want=%b", i, flag, t[i].f);
      end
      mf16 = t[i].f;
    end
  endtask

  task automatic test_backpressure();
    vec_t s[$];
    int   acc = 0;
    s.push_back('{4'h0, 32'h7ffe, 32'h7ffe, 8'h0, 32'h0, 3'b0, 1'b0});
    s.push_back('{4'h1, 32'h0005, 32'h0007, 8'h0, 32'h0, 3'b0, 1'b0});
    s.push_back('{4'h2, 32'h1234, 32'h1234, 8'h0, 32'h0, 3'b0, 1'b0});
    s.push_back('{4'h0, 32'h0001, 32'h0001, 8'h0, 32'h0, 3'b0, 1'b0});
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      iv = (s.size() != 0);
      if (iv) begin
        op = s[0].op; ra = s[0].a[15:0];
        rb = s[0].b[15:0]; imm = s[0].imm;
      end
      ordy = (c >= 7);
      #1;
      checks++;
      if (flag !== mf16) begin
        errors++;
        $display("FAIL bp_flag c=%0d got=%b want=%b", c, flag, mf16);
      end
      if (c >= 2 && c <= 6) begin
        checks++;
        if (ir !== 1'b0 || acc != 2) begin
          errors++;
          $display("FAIL bp_ready c=%0d ir=%b accepts=%0d want ir=0 accepts=2", c, ir, acc);
        end
      end
      if (c >= 2 && c <= 10) begin
        checks++;
        if (ov !== 1'b1) begin
          errors++;
          $display("FAIL bp_valid c=%0d got=%b want=1", c, ov);
        end
      end
      if (ov === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL bp_spurious c=%0d out=%h", c, dout);
        end else begin
          if (dout !== q[0].r[15:0] || fwe !== q[0].wz) begin
            errors++;
            $display("FAIL bp_out c=%0d got=%h/%b want=%h/%b", c, dout, fwe, q[0].r[15:0], q[0].wz);
          end
          if (ordy) begin
            mf16 = upd(mf16, q[0], 16);
            q.delete(0);
          end
        end
      end
      if (iv && ir) begin
        q.push_back(ref_op(16, 4, op, {16'h0, ra}, {16'h0, rb}, imm));
        s.delete(0);
        acc++;
      end
    end
    iv = 1'b0;
    checks++;
    if (q.size() != 0 || acc != 4) begin
      errors++;
      $display("FAIL bp_drain left=%0d accepts=%0d want 0/4", q.size(), acc);
    end
  endtask

  task automatic test_random();
    bit acc = 1'b1;
    for (int c = 0; c < 410; c++) begin
      @(negedge clk);
      if (c >= 400) begin
        iv = 1'b0;
        ordy = 1'b1;
      end else begin
        if (acc || !iv) begin
          iv  = ($urandom_range(0, 3) != 0);
          op  = 4'($urandom_range(0, 15));
          ra  = ($urandom_range(0, 4) == 0) ? 16'h7fff : 16'($urandom);
          rb  = ($urandom_range(0, 4) == 0) ? 16'h8000 : 16'($urandom);
          imm = 8'($urandom);
        end
        ordy = ($urandom_range(0, 9) < 7);
      end
      #1;
      checks++;
      if (flag !== mf16) begin
        errors++;
        $display("FAIL rnd_flag c=%0d got=%b want=%b", c, flag, mf16);
      end
      if (ov === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_spurious c=%0d out=%h", c, dout);
        end else begin
          if (dout !== q[0].r[15:0] || fwe !== q[0].wz) begin
            errors++;
            $display("FAIL rnd_out c=%0d got=%h/%b want=%h/%b", c, dout, fwe, q[0].r[15:0], q[0].wz);
          end
          if (ordy) begin
            mf16 = upd(mf16, q[0], 16);
            q.delete(0);
          end
        end
      end
      acc = iv && ir;
      if (acc) q.push_back(ref_op(16, 4, op, {16'h0, ra}, {16'h0, rb}, imm));
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rnd_drain left=%0d want=0", q.size());
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    iv = 1'b1; op = 4'h0; ra = 16'h7ffe; rb = 16'h7ffe; ordy = 1'b1;
    @(posedge clk);
    #1 iv = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (flag !== 3'b010) begin
      errors++;
      $display("FAIL ar_preflag got=%b want=010", flag);
    end
    ordy = 1'b0;
    iv = 1'b1; op = 4'h1; ra = 16'h0005; rb = 16'h0007;
    @(posedge clk);
    #1;
    @(negedge clk);
    op = 4'h2; ra = 16'h00ff; rb = 16'h0f00;
    @(posedge clk);
    #1 iv = 1'b0;
    #2;
    checks++;
    if (ov !== 1'b1) begin
      errors++;
      $display("FAIL ar_inflight ov=%b want=1", ov);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ov !== 1'b0 || flag !== 3'b000 || fwe !== 1'b0 || dout !== 16'h0) begin
      errors++;
      $display("FAIL ar_async ov=%b flag=%b we=%b out=%h", ov, flag, fwe, dout);
    end
    @(negedge clk);
    rst = 1'b0;
    ordy = 1'b1;
    mf16 = 3'b000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (ov !== 1'b0 || flag !== 3'b000) begin
        errors++;
        $display("FAIL ar_stale c=%0d ov=%b flag=%b", c, ov, flag);
      end
    end
    checks++;
    if (ir !== 1'b1) begin
      errors++;
      $display("FAIL ar_ready got=%b want=1", ir);
    end
  endtask

  task automatic test_w32();
    vec_t t[4];
    t[0] = '{4'h6, 32'h80000001, 32'h0, 8'h01, 32'hc0000000, 3'b000, 1'b1};
    t[1] = '{4'h5, 32'h80000000, 32'h0, 8'h1f, 32'hffffffff, 3'b000, 1'b1};
    t[2] = '{4'h0, 32'h7fffffff, 32'h1, 8'h00, 32'h7fffffff, 3'b010, 1'b1};
    t[3] = '{4'h7, 32'h7f0180ff, 32'h0101ff01, 8'h00, 32'h7f028000, 3'b010, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      iv2 = 1'b1; op2 = t[i].op; ra2 = t[i].a;
      rb2 = t[i].b; imm2 = t[i].imm; ordy2 = 1'b1;
      @(posedge clk);
      #1 iv2 = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (ov2 !== 1'b1 || dout2 !== t[i].r || fwe2 !== t[i].we) begin
        errors++;
        $display("FAIL w32_out[%0d] ov=%b got=%h/%b want=%h/%b", i, ov2, dout2, fwe2, t[i].r, t[i].we);
      end
      @(posedge clk);
      #1;
      checks++;
      if (flag2 !== t[i].f) begin
        errors++;
        $display("FAIL w32_flag[%0d] got=%b want=%b", i, flag2, t[i].f);
      end
    end
  endtask

  initial begin
    iv = 1'b0; op = 4'h0; ra = '0; rb = '0; imm = '0; ordy = 1'b1;
    iv2 = 1'b0; op2 = 4'h0; ra2 = '0; rb2 = '0; imm2 = '0; ordy2 = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_random();
    test_async_reset();
    test_w32();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
